// File: rtl/wave_pc_table.sv
// Per-SIMD program-counter table: one PC and lifecycle state per resident wave slot.
// Serves dispatch (slot load), issue (PC read) and execute (PC advance / branch / halt).
module wave_pc_table #(
  parameter int NUM_WAVES              = 4,
  parameter int PROGRAM_MEM_ADDR_WIDTH = 6,
  parameter int WAVE_ID_WIDTH          = $clog2(NUM_WAVES)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              dispatch_valid,
  input  logic [WAVE_ID_WIDTH-1:0]          dispatch_wave_id,
  input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] dispatch_start_pc,
  input  logic                              update_valid,
  input  logic [WAVE_ID_WIDTH-1:0]          update_wave_id,
  input  logic                              branch_taken,
  input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] branch_target,
  input  logic                              halt,
  input  logic                              retire_valid,
  input  logic [WAVE_ID_WIDTH-1:0]          retire_wave_id,
  input  logic [WAVE_ID_WIDTH-1:0]          rd_wave_id,
  output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] rd_pc,
  output logic                              rd_running,
  output logic [NUM_WAVES-1:0]              running_mask,
  output logic [NUM_WAVES-1:0]              done_mask,
  output logic                              done_pulse,
  output logic                              err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    DONE    = 2'd2
  } slot_state_e;

  typedef logic [PROGRAM_MEM_ADDR_WIDTH-1:0] pc_t;

  pc_t         pc_q    [NUM_WAVES];
  slot_state_e state_q [NUM_WAVES];
  pc_t         pc_d    [NUM_WAVES];
  slot_state_e state_d [NUM_WAVES];
  logic        err_d;
  logic        any_halt;

  // Requests are evaluated against pre-edge state; the three legal actions
  // (dispatch on IDLE, update on RUNNING, retire on DONE) can never collide on a slot.
  always_comb begin
    // NOTE: every comb output gets a default before any branch so no latch is inferred.
    err_d    = err;
    any_halt = 1'b0;
    for (int i = 0; i < NUM_WAVES; i++) begin
      logic disp_hit, upd_hit, ret_hit;
      pc_d[i]    = pc_q[i];
      state_d[i] = state_q[i];
      disp_hit   = dispatch_valid && (dispatch_wave_id == WAVE_ID_WIDTH'(i));
      upd_hit    = update_valid   && (update_wave_id   == WAVE_ID_WIDTH'(i));
      ret_hit    = retire_valid   && (retire_wave_id   == WAVE_ID_WIDTH'(i));

      if (disp_hit) begin
        if (state_q[i] == IDLE) begin
          state_d[i] = RUNNING;
          pc_d[i]    = dispatch_start_pc;
        end else begin
          err_d = 1'b1;
        end
      end

      // A same-slot dispatch always swallows the update, legal or not.
      if (upd_hit) begin
        if (state_q[i] != RUNNING) begin
          err_d = 1'b1;
        end else if (!disp_hit) begin
          if (halt) begin
            state_d[i] = DONE;
            any_halt   = 1'b1;
          end else if (branch_taken) begin
            pc_d[i] = branch_target;
          end else begin
            pc_d[i] = pc_q[i] + pc_t'(1);
          end
        end
      end

      if (ret_hit) begin
        if (state_q[i] == DONE) begin
          state_d[i] = IDLE;
          pc_d[i]    = '0;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      // NOTE: the PC array is reset explicitly because a freed or fresh slot must read 0.
      for (int i = 0; i < NUM_WAVES; i++) begin
        pc_q[i]    <= '0;
        state_q[i] <= IDLE;
      end
      done_pulse <= 1'b0;
      err        <= 1'b0;
    end else if (enable) begin
      for (int i = 0; i < NUM_WAVES; i++) begin
        pc_q[i]    <= pc_d[i];
        state_q[i] <= state_d[i];
      end
      done_pulse <= any_halt;
      err        <= err_d;
    end else begin
      done_pulse <= 1'b0;
    end
  end

  always_comb begin
    running_mask = '0;
    done_mask    = '0;
    for (int i = 0; i < NUM_WAVES; i++) begin
      running_mask[i] = (state_q[i] == RUNNING);
      done_mask[i]    = (state_q[i] == DONE);
    end
  end

  // Issue-stage read sees registered state only; no same-cycle bypass.
  assign rd_pc      = pc_q[rd_wave_id];
  assign rd_running = (state_q[rd_wave_id] == RUNNING);

endmodule
